uart_cmd_decode: RTL

Byte-level command parser between the UART receiver and the SDRAM controller's write-FIFO/arbiter front end. It consumes the receiver's 8-bit byte strobe and recognises two frames. A write frame is a command byte followed by a fixed number of payload bytes, which are pushed into the SDRAM write FIFO. A read frame is a single command byte. For each completed frame the block emits a one-cycle write or read trigger to the SDRAM controller, and it rejects unknown commands and stalled frames.

---
 rtl/uart_cmd_decode.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_cmd_decode.sv
// UART command byte parser feeding the SDRAM write FIFO and arbiter.
// Recognises write frames (CMD_WR + WR_BYTES payload) and single-byte reads.
module uart_cmd_decode #(
    parameter logic [7:0] CMD_WR      = 8'h55,
    parameter logic [7:0] CMD_RD      = 8'hAA,
    parameter int         WR_BYTES    = 4,
    parameter int         TIMEOUT_CYC = 5600
) (
    input  logic       sclk,
    input  logic       s_rst,
    input  logic [7:0] uart_data,
    input  logic       uart_flag,
    output logic       wfifo_wr_en,
    output logic [7:0] wfifo_data,
    output logic       wfifo_clr,
    output logic       wr_trig,
    output logic       rd_trig,
    output logic       cmd_err,
    output logic       busy
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WDATA = 1'b1;

    localparam logic [7:0]    LAST_IDX = 8'(WR_BYTES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 2);

    logic [0:0]    state_q, state_d;
    logic [7:0]    byte_cnt_q, byte_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          pend_q, pend_d;
    logic          wr_en_q, wr_en_d;
    logic [7:0]    data_q, data_d;
    logic          clr_q, clr_d;
    logic          wr_trig_q, wr_trig_d;
    logic          rd_trig_q, rd_trig_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    // Next-state and registered-output logic for the frame parser.
    // The timeout counter tracks idle cycles since the last accepted byte;
    // a byte arriving on the expiry cycle takes priority over the abort.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        tmo_d      = tmo_q;
        pend_d     = 1'b0;
        wr_en_d    = 1'b0;
        data_d     = data_q;
        clr_d      = 1'b0;
        wr_trig_d  = pend_q;
        rd_trig_d  = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (uart_flag) begin
                    if (uart_data == CMD_WR) begin
                        state_d    = WDATA;
                        byte_cnt_d = 8'd0;
                        tmo_d      = '0;
                    end else if (uart_data == CMD_RD) begin
                        rd_trig_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WDATA: begin
                if (uart_flag) begin
                    wr_en_d = 1'b1;
                    data_d  = uart_data;
                    tmo_d   = '0;
                    if (byte_cnt_q == LAST_IDX) begin
                        state_d    = IDLE;
                        byte_cnt_d = 8'd0;
                        pend_d     = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d    = IDLE;
                    byte_cnt_d = 8'd0;
                    tmo_d      = '0;
                    err_d      = 1'b1;
                    clr_d      = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == WDATA);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= 8'd0;
            tmo_q      <= '0;
            pend_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            data_q     <= 8'd0;
            clr_q      <= 1'b0;
            wr_trig_q  <= 1'b0;
            rd_trig_q  <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_q      <= tmo_d;
            pend_q     <= pend_d;
            wr_en_q    <= wr_en_d;
            data_q     <= data_d;
            clr_q      <= clr_d;
            wr_trig_q  <= wr_trig_d;
            rd_trig_q  <= rd_trig_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign wfifo_wr_en = wr_en_q;
    assign wfifo_data  = data_q;
    assign wfifo_clr   = clr_q;
    assign wr_trig     = wr_trig_q;
    assign rd_trig     = rd_trig_q;
    assign cmd_err     = err_q;
    assign busy        = busy_q;

endmodule
